// File: rtl/float_mult_pipe_if.sv
// Operand/result handshake bundle for float_mult_pipe.
// out_flags is present only when FMUL_FLAGS_EN is defined.
interface float_mult_pipe_if #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
`ifdef FMUL_FLAGS_EN
  logic [4:0]   out_flags;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_flags
  );
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_flags
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );
`endif
endinterface

// File: rtl/float_mult_pipe.sv
// Three-stage IEEE-754-style multiplier (unpack, multiply, round/pack), RNE, FTZ.
// Define FMUL_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact, zero} flags.
module float_mult_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  float_mult_pipe_if.slave  io
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] Bias   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);

  // Handshake chain: a stage loads when empty or when the stage after it is draining.
  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;
  assign ld3 = !v3_q || io.out_ready;
  assign ld2 = !v2_q || ld3;
  assign ld1 = !v1_q || ld2;
  assign io.in_ready  = ld1;
  assign io.out_valid = v3_q;

  // S1: unpack and classify
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             s1_sign_d, s1_zero_d, s1_inf_d, s1_nan_d;
  logic signed [EW-1:0] s1_exp_d;
  assign ea = io.in_a[W-2 -: EXP_W];
  assign eb = io.in_b[W-2 -: EXP_W];
  assign fa = io.in_a[MAN_W-1:0];
  assign fb = io.in_b[MAN_W-1:0];
  assign s1_sign_d = io.in_a[W-1] ^ io.in_b[W-1];
  assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - Bias;
  assign s1_zero_d = (ea == '0) || (eb == '0);
  assign s1_inf_d  = (&ea && fa == '0) || (&eb && fb == '0);
  assign s1_nan_d  = (&ea && fa != '0) || (&eb && fb != '0);

  logic                 s1_sign_q, s1_zero_q, s1_inf_q, s1_nan_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [MAN_W:0]       s1_ma_q, s1_mb_q;

  // S2: mantissa product
  logic [PW-1:0] s2_prod_d;
  assign s2_prod_d = {{(MAN_W+1){1'b0}}, s1_ma_q} * {{(MAN_W+1){1'b0}}, s1_mb_q};

  logic                 s2_sign_q, s2_zero_q, s2_inf_q, s2_nan_q;
  logic signed [EW-1:0] s2_exp_q;
  logic [PW-1:0]        s2_prod_q;

  // S3: normalise, round, pack
  logic                 msb, guard, sticky, rnd_up, nan_res, ovf, unf;
  logic [PW-2:0]        nrm;
  logic [MAN_W-1:0]     man;
  logic [MAN_W:0]       man_r;
  logic signed [EW-1:0] exp_inc, exp_f;
  logic [W-1:0]         p_d, p_q;

  always_comb begin
    msb     = s2_prod_q[PW-1];
    nrm     = msb ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
    man     = nrm[PW-2 -: MAN_W];
    guard   = nrm[MAN_W];
    sticky  = |nrm[MAN_W-1:0];
    rnd_up  = guard && (sticky || man[0]);
    man_r   = {1'b0, man} + (MAN_W+1)'(rnd_up);
    exp_inc = EW'(msb) + EW'(man_r[MAN_W]);
    exp_f   = s2_exp_q + exp_inc;
    ovf     = exp_f >= ExpMax;
    unf     = exp_f <= 0;
    nan_res = s2_nan_q || (s2_inf_q && s2_zero_q);

    p_d = {s2_sign_q, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
    if (nan_res) begin
      p_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s2_inf_q || (!s2_zero_q && ovf)) begin
      p_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_zero_q || unf) begin
      p_d = {s2_sign_q, {(W-1){1'b0}}};
    end
  end

`ifdef FMUL_FLAGS_EN
  logic [4:0] flags_d, flags_q;
  logic       special, f_ovf, f_unf;
  always_comb begin
    special = nan_res || s2_inf_q || s2_zero_q;
    f_ovf   = !special && ovf;
    f_unf   = !special && !ovf && unf;
    flags_d = {nan_res, f_ovf, f_unf,
               f_ovf || f_unf || (!special && !ovf && !unf && (guard || sticky)),
               (!nan_res && !s2_inf_q && s2_zero_q) || f_unf};
  end
  assign io.out_flags = flags_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_nan_q  <= 1'b0;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_inf_q  <= 1'b0;
      s2_nan_q  <= 1'b0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      p_q       <= '0;
`ifdef FMUL_FLAGS_EN
      flags_q   <= '0;
`endif
    end else begin
      if (ld1) begin
        v1_q <= io.in_valid;
        if (io.in_valid) begin
          s1_sign_q <= s1_sign_d;
          s1_zero_q <= s1_zero_d;
          s1_inf_q  <= s1_inf_d;
          s1_nan_q  <= s1_nan_d;
          s1_exp_q  <= s1_exp_d;
          s1_ma_q   <= {1'b1, fa};
          s1_mb_q   <= {1'b1, fb};
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          s2_sign_q <= s1_sign_q;
          s2_zero_q <= s1_zero_q;
          s2_inf_q  <= s1_inf_q;
          s2_nan_q  <= s1_nan_q;
          s2_exp_q  <= s1_exp_q;
          s2_prod_q <= s2_prod_d;
        end
      end
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          p_q <= p_d;
`ifdef FMUL_FLAGS_EN
          flags_q <= flags_d;
`endif
        end
      end
    end
  end

  assign io.out_p = p_q;
endmodule

// File: doc/float_mult_pipe.md
Name: float_mult_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier for the coprocessor datapath; default configuration is binary16.
- Accepts one operand pair per cycle over a valid/ready handshake and returns a rounded product three stages later.
- Handles zero, infinity, NaN, overflow and underflow explicitly.
- Uses round-to-nearest-even.

Parameters:
- EXP_W, 5: exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 10: stored mantissa width, hidden bit excluded.
- Derived: W = 1+EXP_W+MAN_W, the total word width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- in_a  in  W  operand A
- in_b  in  W  operand B
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- out_p  out  W  product
- out_flags  out  5  {invalid, overflow, underflow, inexact, zero}; present only with FMUL_FLAGS_EN

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits cleared; out_valid=0, out_p=0, out_flags=0.
  - in_ready=1 after reset.
  - Operations in flight are discarded, never emitted.
- Handshake:
  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
  - out_p and out_valid stay stable while out_valid&&!out_ready.
- Pipeline: 3 register stages S1, S2, S3; S3 drives the outputs.
  - Stage k loads when !valid_k || ready_k, where ready_3 = out_ready.
  - in_ready = !valid_1 || ready_1, combinational from the downstream chain.
  - Latency is 3 cycles from input transfer to out_valid with out_ready held high.
  - Throughput is 1 op/cycle. Bubbles collapse.
- S1, unpack/classify:
  - sign = a.s ^ b.s.
  - Exponent sum uses EXP_W+2 bit signed arithmetic: ea+eb-bias.
  - Hidden bit is prepended to each mantissa.
  - Class flags: zero (exp=0, subnormals flushed to zero), inf, nan.
- S2, multiply: (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits; exponent and class flags pass through.
- S3, normalise/round/pack:
  - If product MSB=1: shift right 1 and exp+1.
  - Guard, round and sticky bits are taken from the bits below MAN_W.
  - Round-to-nearest-even. A mantissa carry-out on rounding gives exp+1 with mantissa 0.
- Specials, in priority order:
  - Any NaN, or inf*zero -> canonical NaN: sign 0, exp all-ones, mantissa MSB 1, rest 0 (fp16 0x7E00).
  - inf*nonzero -> signed inf.
  - zero*finite -> signed zero.
  - Final exp >= all-ones -> signed inf.
  - Final exp <= 0 -> signed zero, no subnormal outputs.

Optional Feature:
- Macro: FMUL_FLAGS_EN.
- When defined:
  - Port out_flags exists and is registered in S3 alongside out_p with the same stall behaviour.
  - invalid = NaN operand or inf*zero.
  - overflow = finite operands giving inf.
  - underflow = nonzero finite result flushed to zero.
  - inexact = any discarded nonzero bit, or overflow/underflow.
  - zero = result is ±0.
- When undefined: port absent, no flag logic; datapath results identical.

Test Plan:
- fp16 0x3E00*0x4000, out_ready=1 -> out_p=0x4200 exactly 3 cycles after transfer; flags zero.
- 0x3C01*0x3C01 -> 0x3C02 (round down).
- 0x3C01*0x3BFF -> 0x3C00, inexact=1.
- 0x7BFF*0x7BFF -> 0x7C00, overflow=1.
- 0x0400*0x3800 -> 0x0000, underflow=1.
- 0x8400*0x3800 -> 0x8000.
- 0x7C00*0x0000 -> 0x7E00, invalid=1.
- 0x7E00*0x3C00 -> 0x7E00.
- 0xFC00*0x4000 -> 0xFC00.
- 8 back-to-back ops with out_ready toggled 1,0,0,1,...:
  - All 8 results appear in order and none are lost or duplicated.
  - out_p is stable during stalls.
  - in_ready drops only when all 3 stages are full and out_ready=0.
- Assert rst_n low while 3 ops are in flight -> out_valid=0 immediately (asynchronous); after release no stale result appears, and the next op emits correctly.
